data_syn_tx: RTL

DATA_SYN_TX -- requirements
Module: data_syn_tx

---
 rtl/data_syn_pkg.sv | 20 ++
 rtl/ack_sync.sv | 24 ++
 rtl/data_syn_tx.sv | 119 +++++++++++
 3 files changed

// File: rtl/data_syn_pkg.sv
// Shared state encoding and default parameter values for the data_syn_tx launcher.
// Optional feature macro: ACK_HANDSHAKE_EN adds the WAIT_ACK_LOW state.
package data_syn_pkg;

    localparam int DEF_BUS_WIDTH   = 2;
    localparam int DEF_HOLD_CYCLES = 6;
    localparam int DEF_GAP_CYCLES  = 2;
    localparam int DEF_NUM_STAGES  = 2;

`ifdef ACK_HANDSHAKE_EN
    typedef enum logic [1:0] {IDLE, HOLD, GAP, WAIT_ACK_LOW} state_t;
`else
    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
`endif

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ack_sync.sv
// Multi-flop synchronizer bringing the destination-domain ack into CLK.
// Latency NUM_STAGES edges; no backpressure.
module ack_sync #(
    parameter int NUM_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic ack,
    output logic ack_s
);

    logic [NUM_STAGES-1:0] sync_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[NUM_STAGES-2:0], ack};
        end
    end

    assign ack_s = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/data_syn_tx.sv
// Launches a word onto a quasi-static bus with an enable pulse for a multi-flop receiver.
// Latency 1 cycle accept->bus; in_ready only in IDLE, words offered while busy are dropped.
// Macro ACK_HANDSHAKE_EN: enable held until a synchronized ack instead of a fixed count.
module data_syn_tx
    import data_syn_pkg::*;
#(
    parameter int BUS_WIDTH   = DEF_BUS_WIDTH,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int NUM_STAGES  = DEF_NUM_STAGES
) (
    input  logic                 CLK,
    input  logic                 RST,
`ifdef ACK_HANDSHAKE_EN
    input  logic                 ack,
`endif
    input  logic [BUS_WIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [BUS_WIDTH-1:0] Unsync_bus,
    output logic                 bus_enable,
    output logic                 busy
);

    localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES) + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0]   bus_q, bus_d;
    logic                   en_q, en_d;

`ifdef ACK_HANDSHAKE_EN
    logic ack_s;

    ack_sync #(.NUM_STAGES(NUM_STAGES)) u_ack_sync (
        .CLK   (CLK),
        .RST   (RST),
        .ack   (ack),
        .ack_s (ack_s)
    );
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bus_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bus_q   <= bus_d;
            en_q    <= en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bus_d   = bus_q;
        en_d    = en_q;
        case (state_q)
            IDLE: begin
                // The bus only ever changes here, so it is stable whenever enable is high.
                if (in_valid) begin
                    bus_d   = in_data;
                    en_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
`ifdef ACK_HANDSHAKE_EN
                if (ack_s) begin
                    en_d    = 1'b0;
                    state_d = WAIT_ACK_LOW;
                end
`else
                if (cnt_q == HOLD_LAST) begin
                    en_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
`ifdef ACK_HANDSHAKE_EN
            WAIT_ACK_LOW: begin
                if (!ack_s) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end
            end
`endif
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign Unsync_bus = bus_q;
    assign bus_enable = en_q;

endmodule
